bcd_scan_counter: RTL

// - Parametrised N-digit BCD up/down counter with a built-in multiplexed seven-segment scan driver.
// - Adds run/direction control, parallel load, a wrap flag and parametrised dividers.
// - Sits between the board clock and the common-anode display pins. Top level is wiring only.

---
 rtl/bcd_scan_counter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with run/load control and a multiplexed seven-segment scan driver.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module bcd_scan_counter #(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 5_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                wrap,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   segcom
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]       tick_cnt;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       scan_idx;
  logic [IW-1:0]       scan_idx_nxt;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;
  logic                step_wrap;
  logic                chain;
  logic [3:0]          digit;
  logic [3:0]          cur_digit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign tick = run && (tick_cnt == TICK_LAST);

  // Carry/borrow ripples through every digit in one cycle; a chain surviving the top digit is a wrap.
  always_comb begin
    stepped = count;
    chain   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (chain) begin
        if (up_dn) begin
          if (digit == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = digit + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = digit - 4'd1;
            chain = 1'b0;
          end
        end
      end
    end
    step_wrap = chain;
  end

  always_comb begin
    loaded = '0;
    for (int i = 0; i < DIGITS; i++) begin
      loaded[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      tick_cnt <= '0;
      wrap     <= 1'b0;
    end else if (load) begin
      count    <= loaded;
      tick_cnt <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (run) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          count    <= stepped;
          wrap     <= step_wrap;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

  assign scan_idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      segcom   <= ~DIGITS'(1);
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx_nxt;
      segcom   <= ~(DIGITS'(1) << scan_idx_nxt);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) cur_digit = count[4*i +: 4];
    end
  end

`ifdef LZ_BLANK_EN
  logic lead;
  logic blank;

  // Walk down from the top digit; a selected digit is blank while it and everything above it are zero.
  always_comb begin
    lead  = 1'b1;
    blank = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (count[4*i +: 4] != 4'd0) lead = 1'b0;
      if (scan_idx == IW'(i)) blank = lead && (i != 0);
    end
  end

  assign seg = blank ? 7'b1111111 : glyph(cur_digit);
`else
  assign seg = glyph(cur_digit);
`endif

endmodule
